digit_motion_scheduler: RTL and testbench
=========================================

Name: digit_motion_scheduler

Overview:
- Owns the on-screen (X,Y) positions of NUM_DIGITS VGA 7-segment digits and moves them periodically.
- Moves are synchronised to the frame: one move every FRAME_DIV frame ticks, issued at the start of vertical blank.
- A single shared wrap-around adder serves all digits, round-robin, one digit per clock.
- Replaces free-running per-digit timers so that all digits move in the same blanking interval.

Parameters:
NUM_DIGITS, 4, number of digit positions managed
H_ACTIVE, 640, horizontal wrap modulus (X range 0..H_ACTIVE-1)
V_ACTIVE, 480, vertical wrap modulus (Y range 0..V_ACTIVE-1)
FRAME_DIV, 30, frame ticks per move (>=1)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high
frame_tick  in  1  one-cycle pulse at start of vertical blank
load  in  1  one-cycle pulse: load init positions
init_x  in  10*NUM_DIGITS  packed initial X, digit i at [10i+9:10i]
init_y  in  10*NUM_DIGITS  packed initial Y, same packing
step_x  in  10  X increment per move, common to all digits
step_y  in  10  Y increment per move, common to all digits
enable_mask  in  NUM_DIGITS  bit i=1: digit i moves
digit_x  out  10*NUM_DIGITS  packed current X positions (registered)
digit_y  out  10*NUM_DIGITS  packed current Y positions (registered)
busy  out  1  high while in UPDATE
update_done  out  1  one-cycle pulse after a full sweep
overrun  out  1  one-cycle pulse when a move trigger is dropped

Behaviour:
- Reset:
  - all digit_x/digit_y = 0; state IDLE; divider = 0; idx = 0.
  - busy, update_done and overrun = 0.
- Divider:
  - Increments on each frame_tick.
  - On a frame_tick while divider == FRAME_DIV-1: divider returns to 0 and a move trigger is raised.
- States:
  - IDLE:
    - On trigger -> UPDATE, idx = 0.
    - busy goes high the cycle after the trigger edge.
  - UPDATE, per cycle:
    - Apply shared adder to digit[idx] if enable_mask[idx] == 1; otherwise leave it unchanged.
    - idx++.
    - At the edge that processes idx == NUM_DIGITS-1 -> IDLE; update_done = 1 for the next cycle only.
    - Sweep takes exactly NUM_DIGITS cycles; busy is high for exactly those NUM_DIGITS cycles.
- Shared adder (11-bit intermediate):
  - sx = x + sat(step_x, H_ACTIVE-1); new x = sx - H_ACTIVE if sx >= H_ACTIVE, else sx.
  - Y likewise with V_ACTIVE.
  - sat(v, m) = min(v, m); positions therefore always stay in range.
- enable_mask is sampled per digit in that digit's UPDATE cycle, not at the trigger.
- load, from any state:
  - Each digit_x[i] = init_x[i] if < H_ACTIVE, else 0; each digit_y[i] = init_y[i] if < V_ACTIVE, else 0.
  - State -> IDLE; divider = 0; idx = 0.
  - Load during UPDATE aborts the sweep with no update_done.
  - load has priority over frame_tick in the same cycle; that tick is ignored.
- frame_tick during UPDATE:
  - The divider still counts it.
  - If it produces a trigger, the trigger is dropped and overrun pulses for one cycle; the current sweep continues.
- Simultaneous reset and load: reset wins.
- Outputs change only at clock edges; no combinational path from inputs to outputs.

Test Plan:
1. Reset, then load with init_x = {0,100,200,630}, init_y = {0,40,80,470}, step (100,40), mask 4'b1111, FRAME_DIV = 2 -> after the 2nd frame_tick, busy is high for 4 cycles, then update_done pulses. Result: X = {100,200,300,90}, Y = {40,80,120,30} (630+100 -> 90, 470+40 -> 30).
2. Same setup with mask 4'b0101 -> only digits 0 and 2 move; digits 1 and 3 hold 100/40 and 630/470.
3. Load asserted in the 2nd UPDATE cycle -> state IDLE and positions equal init values. No update_done; the next move needs 2 fresh frame_ticks.
4. FRAME_DIV = 1, NUM_DIGITS = 4, frame_tick in back-to-back cycles -> first tick starts the sweep. Second tick pulses overrun, the sweep completes normally, and only one update_done is seen.
5. Load init_x = 700, init_y = 500, then step_x = 1023, step_y = 1023 -> loaded positions are 0,0. After one move: X = 639, Y = 479; after a second move: X = 638, Y = 478.
6. Assert reset mid-sweep -> the next cycle has all positions 0, busy = 0, no update_done pulse, and divider = 0.

Source files
------------

// File: rtl/digit_motion_scheduler.sv
// Frame-synchronised position scheduler for VGA 7-segment digits: every FRAME_DIV
// frame ticks one shared wrap-around adder sweeps all digits, one digit per clock.
module digit_motion_scheduler #(
  parameter int NUM_DIGITS = 4,
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int FRAME_DIV  = 30
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    frame_tick,
  input  logic                    load,
  input  logic [10*NUM_DIGITS-1:0] init_x,
  input  logic [10*NUM_DIGITS-1:0] init_y,
  input  logic [9:0]              step_x,
  input  logic [9:0]              step_y,
  input  logic [NUM_DIGITS-1:0]   enable_mask,
  output logic [10*NUM_DIGITS-1:0] digit_x,
  output logic [10*NUM_DIGITS-1:0] digit_y,
  output logic                    busy,
  output logic                    update_done,
  output logic                    overrun
);

  localparam int DW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(FRAME_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
  localparam logic [10:0]   H_MOD    = 11'(H_ACTIVE);
  localparam logic [10:0]   V_MOD    = 11'(V_ACTIVE);
  localparam logic [10:0]   H_MAX    = 11'(H_ACTIVE - 1);
  localparam logic [10:0]   V_MAX    = 11'(V_ACTIVE - 1);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_UPDATE = 1'b1
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [DW-1:0] r_div, w_div_nxt;
  logic [IW-1:0] r_idx, w_idx_nxt;
  logic [9:0]    r_x [NUM_DIGITS];
  logic [9:0]    r_y [NUM_DIGITS];
  logic          r_busy, r_done, r_ovr;
  logic          w_done_nxt, w_ovr_nxt, w_wr_en, w_trig;
  logic [9:0]    w_new_x, w_new_y;

  // Step is clamped below the modulus so a single conditional subtract always wraps back into range.
  function automatic logic [9:0] wrap_add(input logic [9:0] pos, input logic [9:0] step,
                                          input logic [10:0] modulus, input logic [10:0] max_step);
    logic [10:0] sat;
    logic [10:0] sum;
    sat = ({1'b0, step} > max_step) ? max_step : {1'b0, step};
    sum = {1'b0, pos} + sat;
    if (sum >= modulus) begin
      wrap_add = 10'(sum - modulus);
    end else begin
      wrap_add = sum[9:0];
    end
  endfunction

  assign w_new_x = wrap_add(r_x[r_idx], step_x, H_MOD, H_MAX);
  assign w_new_y = wrap_add(r_y[r_idx], step_y, V_MOD, V_MAX);

  // Next-state logic: frame divider, trigger/overrun detection and sweep sequencing.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_div_nxt   = r_div;
    w_done_nxt  = 1'b0;
    w_ovr_nxt   = 1'b0;
    w_wr_en     = 1'b0;
    w_trig      = 1'b0;
    if (load) begin
      w_state_nxt = ST_IDLE;
      w_idx_nxt   = '0;
      w_div_nxt   = '0;
    end else begin
      if (frame_tick) begin
        if (r_div == DIV_LAST) begin
          w_div_nxt = '0;
          w_trig    = 1'b1;
        end else begin
          w_div_nxt = r_div + 1'b1;
        end
      end else begin
        w_div_nxt = r_div;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_trig) begin
            w_state_nxt = ST_UPDATE;
            w_idx_nxt   = '0;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        ST_UPDATE: begin
          w_wr_en   = enable_mask[r_idx];
          w_ovr_nxt = w_trig;
          if (r_idx == IDX_LAST) begin
            w_state_nxt = ST_IDLE;
            w_idx_nxt   = '0;
            w_done_nxt  = 1'b1;
          end else begin
            w_idx_nxt = r_idx + 1'b1;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_idx_nxt   = '0;
        end
      endcase
    end
  end

  // State, status flags and position registers; load overrides any in-flight sweep.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_div   <= '0;
      r_idx   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_ovr   <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        r_x[i] <= 10'd0;
        r_y[i] <= 10'd0;
      end
    end else begin
      r_state <= w_state_nxt;
      r_div   <= w_div_nxt;
      r_idx   <= w_idx_nxt;
      r_busy  <= (w_state_nxt == ST_UPDATE);
      r_done  <= w_done_nxt;
      r_ovr   <= w_ovr_nxt;
      if (load) begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
          r_x[i] <= ({1'b0, init_x[10*i +: 10]} < H_MOD) ? init_x[10*i +: 10] : 10'd0;
          r_y[i] <= ({1'b0, init_y[10*i +: 10]} < V_MOD) ? init_y[10*i +: 10] : 10'd0;
        end
      end else if (w_wr_en) begin
        r_x[r_idx] <= w_new_x;
        r_y[r_idx] <= w_new_y;
      end
    end
  end

  genvar g;
  generate
    for (g = 0; g < NUM_DIGITS; g++) begin : g_pack
      assign digit_x[10*g +: 10] = r_x[g];
      assign digit_y[10*g +: 10] = r_y[g];
    end
  endgenerate

  assign busy        = r_busy;
  assign update_done = r_done;
  assign overrun     = r_ovr;

endmodule

// File: tb/tb_digit_motion_scheduler.sv
// Randomised bench for digit_motion_scheduler: a behavioural model predicts positions,
// busy and pulses; a monitor compares every cycle and pops sweep snapshots on update_done.
module tb_digit_motion_scheduler;
  localparam int N    = 4;
  localparam int H    = 640;
  localparam int V    = 480;
  localparam int FDIV = 2;

  logic          clock = 1'b0;
  logic          reset, frame_tick, load;
  logic [10*N-1:0] init_x, init_y, digit_x, digit_y;
  logic [9:0]    step_x, step_y;
  logic [N-1:0]  enable_mask;
  logic          busy, update_done, overrun;

  always #5 clock = ~clock;

  digit_motion_scheduler #(.NUM_DIGITS(N), .H_ACTIVE(H), .V_ACTIVE(V), .FRAME_DIV(FDIV)) dut (
    .clock(clock), .reset(reset), .frame_tick(frame_tick), .load(load),
    .init_x(init_x), .init_y(init_y), .step_x(step_x), .step_y(step_y),
    .enable_mask(enable_mask), .digit_x(digit_x), .digit_y(digit_y),
    .busy(busy), .update_done(update_done), .overrun(overrun)
  );

  typedef struct {
    logic [10*N-1:0] x;
    logic [10*N-1:0] y;
  } snap_t;

  int    mx [N];
  int    my [N];
  int    m_div, m_idx;
  bit    m_sweep, m_busy, m_done, m_ovr;
  snap_t done_q[$];
  int    ovr_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  bit    armed   = 1'b0;

  logic [10*N-1:0] nx_init_x, nx_init_y;
  logic [9:0]      nx_step_x, nx_step_y;
  logic [N-1:0]    nx_mask;

  task automatic chk(input string nm, input logic [10*N-1:0] act, input logic [10*N-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Model of what the next clock edge does, written from the rules with modulo arithmetic.
  task automatic model_edge(input bit rst, input bit ld, input bit tk);
    bit    trig;
    int    sx, sy;
    snap_t s;
    m_done = 1'b0;
    m_ovr  = 1'b0;
    if (rst) begin
      for (int i = 0; i < N; i++) begin mx[i] = 0; my[i] = 0; end
      m_div = 0; m_sweep = 1'b0; m_idx = 0;
    end else if (ld) begin
      for (int i = 0; i < N; i++) begin
        mx[i] = (int'(init_x[10*i +: 10]) < H) ? int'(init_x[10*i +: 10]) : 0;
        my[i] = (int'(init_y[10*i +: 10]) < V) ? int'(init_y[10*i +: 10]) : 0;
      end
      m_div = 0; m_sweep = 1'b0; m_idx = 0;
    end else begin
      trig = 1'b0;
      if (tk) begin
        m_div++;
        if (m_div == FDIV) begin m_div = 0; trig = 1'b1; end
      end
      if (m_sweep) begin
        sx = (int'(step_x) > H - 1) ? H - 1 : int'(step_x);
        sy = (int'(step_y) > V - 1) ? V - 1 : int'(step_y);
        if (enable_mask[m_idx]) begin
          mx[m_idx] = (mx[m_idx] + sx) % H;
          my[m_idx] = (my[m_idx] + sy) % V;
        end
        m_idx++;
        if (m_idx == N) begin
          m_sweep = 1'b0;
          m_done  = 1'b1;
          for (int i = 0; i < N; i++) begin
            s.x[10*i +: 10] = 10'(mx[i]);
            s.y[10*i +: 10] = 10'(my[i]);
          end
          done_q.push_back(s);
        end
        if (trig) begin m_ovr = 1'b1; ovr_q.push_back(1); end
      end else if (trig) begin
        m_sweep = 1'b1;
        m_idx   = 0;
      end
    end
    m_busy = m_sweep;
  endtask

  task automatic cyc(input bit rst, input bit ld, input bit tk);
    @(negedge clock);
    reset = rst; load = ld; frame_tick = tk;
    init_x = nx_init_x; init_y = nx_init_y;
    step_x = nx_step_x; step_y = nx_step_y; enable_mask = nx_mask;
    model_edge(rst, ld, tk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0);
  endtask

  task automatic move();
    cyc(1'b0, 1'b0, 1'b1); idle(1); cyc(1'b0, 1'b0, 1'b1); idle(6);
  endtask

  // Monitor: per-cycle state checks plus scoreboard pops on the DUT's pulses.
  initial begin
    snap_t s;
    logic [10*N-1:0] ex, ey;
    forever begin
      @(posedge clock);
      #1;
      if (armed) begin
        for (int i = 0; i < N; i++) begin
          ex[10*i +: 10] = 10'(mx[i]);
          ey[10*i +: 10] = 10'(my[i]);
        end
        chk("digit_x", digit_x, ex);
        chk("digit_y", digit_y, ey);
        chk("busy", 40'(busy), 40'(m_busy));
        chk("update_done", 40'(update_done), 40'(m_done));
        chk("overrun", 40'(overrun), 40'(m_ovr));
        if (update_done) begin
          if (done_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL sb_done at %0t: got update_done=1 expected no sweep completion", $time);
          end else begin
            s = done_q.pop_front();
            chk("sb_done_x", digit_x, s.x);
            chk("sb_done_y", digit_y, s.y);
          end
        end
        if (overrun) begin
          if (ovr_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL sb_overrun at %0t: got overrun=1 expected no dropped trigger", $time);
          end else begin
            void'(ovr_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    reset = 1'b1; load = 1'b0; frame_tick = 1'b0;
    init_x = '0; init_y = '0; step_x = '0; step_y = '0; enable_mask = '0;
    nx_init_x = '0; nx_init_y = '0; nx_step_x = '0; nx_step_y = '0; nx_mask = '0;
    model_edge(1'b1, 1'b0, 1'b0);
    armed = 1'b1;
    cyc(1'b1, 1'b0, 1'b0);

    // Basic sweep with wrap on digit 3
    nx_init_x = {10'd630, 10'd200, 10'd100, 10'd0};
    nx_init_y = {10'd470, 10'd80, 10'd40, 10'd0};
    nx_step_x = 10'd100; nx_step_y = 10'd40; nx_mask = 4'b1111;
    cyc(1'b0, 1'b1, 1'b0); move();

    // Partial mask
    nx_mask = 4'b0101;
    cyc(1'b0, 1'b1, 1'b0); move();

    // Load in the second UPDATE cycle aborts; a single fresh tick must not move
    nx_mask = 4'b1111;
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b1); idle(1); cyc(1'b0, 1'b0, 1'b1);
    idle(1); cyc(1'b0, 1'b1, 1'b0); idle(6);
    cyc(1'b0, 1'b0, 1'b1); idle(6);
    cyc(1'b0, 1'b0, 1'b1); idle(6);

    // Trigger during a sweep is dropped with overrun
    cyc(1'b0, 1'b1, 1'b0);
    repeat (4) cyc(1'b0, 1'b0, 1'b1);
    idle(6);

    // Out-of-range loads and saturated steps
    nx_init_x = {10'd5, 10'd1023, 10'd640, 10'd700};
    nx_init_y = {10'd479, 10'd480, 10'd1023, 10'd500};
    nx_step_x = 10'd1023; nx_step_y = 10'd1023;
    cyc(1'b0, 1'b1, 1'b0); move(); move();

    // Reset mid-sweep, then a lone tick must not trigger; reset beats load
    nx_step_x = 10'd100; nx_step_y = 10'd40;
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b1); idle(1); cyc(1'b0, 1'b0, 1'b1); idle(2);
    cyc(1'b1, 1'b0, 1'b0); idle(3);
    cyc(1'b0, 1'b0, 1'b1); idle(6);
    cyc(1'b1, 1'b1, 1'b0); idle(2);

    // Random traffic; mask changes every cycle to exercise per-digit sampling
    for (int k = 0; k < 600; k++) begin
      nx_mask = 4'($urandom);
      if ($urandom_range(0, 15) == 0) begin
        nx_step_x = 10'($urandom); nx_step_y = 10'($urandom);
      end
      if ($urandom_range(0, 7) == 0) begin
        for (int i = 0; i < N; i++) begin
          nx_init_x[10*i +: 10] = 10'($urandom_range(0, 1023));
          nx_init_y[10*i +: 10] = 10'($urandom_range(0, 700));
        end
      end
      cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 39) == 0), ($urandom_range(0, 2) == 0));
    end
    idle(8);
    @(negedge clock);
    chk("done_q_empty", 40'(done_q.size()), 40'd0);
    chk("ovr_q_empty", 40'(ovr_q.size()), 40'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
